// File: rtl/rv32im_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rv32im_pkg
//  Description : Shared types and constants for the RV32M divide sequencer:
//                FSM state encoding, divide funct3 codes, default XLEN.
//  Revision    : 1.0 - initial release
// ============================================================================
package rv32im_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [2:0] F3_DIV  = 3'b100;
    localparam logic [2:0] F3_DIVU = 3'b101;
    localparam logic [2:0] F3_REM  = 3'b110;
    localparam logic [2:0] F3_REMU = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage : rv32im_pkg
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
//  Module      : div_step
//  Description : One radix-2 restoring division iteration (combinational).
//                Shifts rem:quot left by one, trial-subtracts the divisor and
//                shifts the resulting quotient bit into quot.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_step #(
    parameter int XLEN = 32
)(
    input  logic [XLEN:0]   i_rem,
    input  logic [XLEN-1:0] i_quot,
    input  logic [XLEN-1:0] i_divisor,
    output logic [XLEN:0]   o_rem,
    output logic [XLEN-1:0] o_quot
);

    logic [XLEN+1:0] w_shift;
    logic [XLEN+1:0] w_trial;
    logic            w_borrow;

    // Trial subtract one bit wider than the remainder so the borrow lands in the MSB
    always_comb begin
        w_shift  = {i_rem, i_quot[XLEN-1]};
        w_trial  = w_shift - {2'b00, i_divisor};
        w_borrow = w_trial[XLEN+1];
        o_rem    = w_borrow ? w_shift[XLEN:0] : w_trial[XLEN:0];
        o_quot   = {i_quot[XLEN-2:0], ~w_borrow};
    end

endmodule : div_step
`default_nettype wire

// File: rtl/mdu_div_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_div_sequencer
//  Description : Multi-cycle RV32M DIV/DIVU/REM/REMU controller for the EX
//                stage. Runs XLEN restoring iterations on operand magnitudes,
//                applies sign fixup and the architectural special cases, and
//                stalls the upstream pipeline while busy.
//  Config      : DIV_FASTPATH_EN - divide-by-zero and signed overflow go
//                straight from IDLE to DONE instead of iterating.
//  Revision    : 1.0 - initial release
// ============================================================================
module mdu_div_sequencer
    import rv32im_pkg::*;
#(
    parameter int XLEN      = XLEN_DEFAULT,
    parameter int REGADDR_W = 5
)(
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 div_valid,
    input  logic [2:0]           div_funct3,
    input  logic [XLEN-1:0]      div_a,
    input  logic [XLEN-1:0]      div_b,
    input  logic [REGADDR_W-1:0] div_rd,
    input  logic                 kill,
    output logic                 stall,
    output logic                 busy,
    output logic                 done,
    output logic [XLEN-1:0]      result,
    output logic [REGADDR_W-1:0] rd_out
);

    localparam int                 c_CNT_W    = $clog2(XLEN);
    localparam logic [c_CNT_W-1:0] c_CNT_INIT = c_CNT_W'(XLEN - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [XLEN-1:0]    c_INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    div_state_t           r_state;
    div_state_t           w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [XLEN:0]        r_rem;
    logic [XLEN:0]        w_rem_nxt;
    logic [XLEN-1:0]      r_quot;
    logic [XLEN-1:0]      w_quot_nxt;
    logic [XLEN-1:0]      r_divisor;
    logic [XLEN-1:0]      r_a;
    logic                 r_neg_q;
    logic                 r_neg_r;
    logic                 r_is_rem;
    logic                 r_b_zero;
    logic                 r_ovf;
    logic [REGADDR_W-1:0] r_rd;
    logic [REGADDR_W-1:0] r_rd_out;
    logic [XLEN-1:0]      r_result;

    logic                 w_signed;
    logic                 w_is_rem;
    logic                 w_a_neg;
    logic                 w_b_neg;
    logic                 w_b_zero;
    logic                 w_ovf;
    logic                 w_accept;
    logic                 w_done;
    logic                 w_stall;
    logic [XLEN-1:0]      w_a_abs;
    logic [XLEN-1:0]      w_b_abs;
    logic [XLEN-1:0]      w_quot_res;
    logic [XLEN-1:0]      w_rem_res;
    logic [XLEN-1:0]      w_final;

    // Operand decode: signedness, magnitudes and special-case detection
    assign w_signed = (div_funct3 == F3_DIV) || (div_funct3 == F3_REM);
    assign w_is_rem = (div_funct3 == F3_REM) || (div_funct3 == F3_REMU);
    assign w_a_neg  = w_signed & div_a[XLEN-1];
    assign w_b_neg  = w_signed & div_b[XLEN-1];
    assign w_a_abs  = w_a_neg ? -div_a : div_a;
    assign w_b_abs  = w_b_neg ? -div_b : div_b;
    assign w_b_zero = (div_b == '0);
    assign w_ovf    = w_signed && (div_a == c_INT_MIN) && (div_b == '1);
    assign w_accept = (r_state == IDLE) && div_valid && !kill;

    div_step #(
        .XLEN (XLEN)
    ) u_div_step (
        .i_rem     (r_rem),
        .i_quot    (r_quot),
        .i_divisor (r_divisor),
        .o_rem     (w_rem_nxt),
        .o_quot    (w_quot_nxt)
    );

    // State register
    always_ff @(posedge clk or posedge clr) begin
        if (clr) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state, stall and done-pulse decode; kill always wins
    always_comb begin
        w_state_nxt = r_state;
        w_stall     = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                w_stall = div_valid;
                if (w_accept) begin
`ifdef DIV_FASTPATH_EN
                    if (w_b_zero || w_ovf) w_state_nxt = DONE;
                    else                   w_state_nxt = BUSY;
`else
                    w_state_nxt = BUSY;
`endif
                end
            end
            BUSY: begin
                w_stall = 1'b1;
                if (kill)              w_state_nxt = IDLE;
                else if (r_cnt == '0)  w_state_nxt = DONE;
            end
            DONE: begin
                w_done      = !kill;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Iteration counter: loaded on accept, counts down once per BUSY cycle
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= c_CNT_INIT;
        end else if ((r_state == BUSY) && !kill && (r_cnt != '0)) begin
            r_cnt <= r_cnt - c_CNT_ONE;
        end
    end

    // Operand capture and restoring iteration datapath
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_rem     <= '0;
            r_quot    <= '0;
            r_divisor <= '0;
            r_a       <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_is_rem  <= 1'b0;
            r_b_zero  <= 1'b0;
            r_ovf     <= 1'b0;
            r_rd      <= '0;
        end else if (w_accept) begin
            r_rem     <= '0;
            r_quot    <= w_a_abs;
            r_divisor <= w_b_abs;
            r_a       <= div_a;
            r_neg_q   <= w_a_neg ^ w_b_neg;
            r_neg_r   <= w_a_neg;
            r_is_rem  <= w_is_rem;
            r_b_zero  <= w_b_zero;
            r_ovf     <= w_ovf;
            r_rd      <= div_rd;
        end else if ((r_state == BUSY) && !kill) begin
            r_rem     <= w_rem_nxt;
            r_quot    <= w_quot_nxt;
        end
    end

    // Sign fixup, then the architectural divide-by-zero / overflow overrides
    always_comb begin
        w_quot_res = r_neg_q ? -r_quot : r_quot;
        w_rem_res  = r_neg_r ? -r_rem[XLEN-1:0] : r_rem[XLEN-1:0];
        if (r_b_zero) begin
            w_quot_res = '1;
            w_rem_res  = r_a;
        end else if (r_ovf) begin
            w_quot_res = c_INT_MIN;
            w_rem_res  = '0;
        end
        w_final = r_is_rem ? w_rem_res : w_quot_res;
    end

    // Completed result holding register; untouched by killed operations
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_result <= '0;
            r_rd_out <= '0;
        end else if (w_done) begin
            r_result <= w_final;
            r_rd_out <= r_rd;
        end
    end

    assign stall  = w_stall & ~clr;
    assign busy   = (r_state != IDLE);
    assign done   = w_done;
    assign result = w_done ? w_final : r_result;
    assign rd_out = w_done ? r_rd : r_rd_out;

endmodule : mdu_div_sequencer
`default_nettype wire

// File: tb/tb_mdu_div_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mdu_div_sequencer
//  Description : Directed self-checking bench for mdu_div_sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu_div_sequencer;

`ifdef DIV_FASTPATH_EN
    localparam int SP_LAT = 1;
`else
    localparam int SP_LAT = 33;
`endif

    localparam logic [2:0] DIV  = 3'b100;
    localparam logic [2:0] DIVU = 3'b101;
    localparam logic [2:0] REM  = 3'b110;
    localparam logic [2:0] REMU = 3'b111;

    logic        clk;
    logic        clr;
    logic        div_valid;
    logic [2:0]  div_funct3;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic [4:0]  div_rd;
    logic        kill;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int n_cmp = 0;
    int n_err = 0;

    mdu_div_sequencer #(
        .XLEN      (32),
        .REGADDR_W (5)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .div_valid  (div_valid),
        .div_funct3 (div_funct3),
        .div_a      (div_a),
        .div_b      (div_b),
        .div_rd     (div_rd),
        .kill       (kill),
        .stall      (stall),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .rd_out     (rd_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one op in the next cycle (cycle 0) and observe cycles 1..45
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, output int n_stall, output int t_done,
                          output logic [31:0] res, output logic [4:0] rdo, output int n_done);
        n_stall = 0; t_done = -1; n_done = 0; res = 'x; rdo = 'x;
        @(negedge clk);
        div_valid = 1'b1; div_funct3 = f3; div_a = a; div_b = b; div_rd = rd;
        #1;
        if (stall) n_stall++;
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            div_valid = 1'b0;
            #1;
            if (stall) n_stall++;
            if (done) begin
                n_done++;
                if (t_done < 0) begin
                    t_done = k; res = result; rdo = rd_out;
                end
            end
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        div_valid = 1'b1;
        #1;
        n_cmp++; if (stall !== 1'b0)   begin n_err++; $display("FAIL reset_stall: got %b exp 0", stall); end
        n_cmp++; if (busy !== 1'b0)    begin n_err++; $display("FAIL reset_busy: got %b exp 0", busy); end
        n_cmp++; if (done !== 1'b0)    begin n_err++; $display("FAIL reset_done: got %b exp 0", done); end
        n_cmp++; if (result !== 32'h0) begin n_err++; $display("FAIL reset_result: got %h exp 0", result); end
        n_cmp++; if (rd_out !== 5'h0)  begin n_err++; $display("FAIL reset_rd_out: got %h exp 0", rd_out); end
        div_valid = 1'b0;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic test_unsigned;
        int ns, td, nd; logic [31:0] r; logic [4:0] d;
        run_op(DIVU, 32'd100, 32'd7, 5'd4, ns, td, r, d, nd);
        n_cmp++; if (ns !== 33)     begin n_err++; $display("FAIL divu_stall_cycles: got %0d exp 33", ns); end
        n_cmp++; if (td !== 33)     begin n_err++; $display("FAIL divu_done_cycle: got %0d exp 33", td); end
        n_cmp++; if (nd !== 1)      begin n_err++; $display("FAIL divu_done_count: got %0d exp 1", nd); end
        n_cmp++; if (r !== 32'd14)  begin n_err++; $display("FAIL divu_result: got %h exp %h", r, 32'd14); end
        n_cmp++; if (d !== 5'd4)    begin n_err++; $display("FAIL divu_rd: got %0d exp 4", d); end
        run_op(REMU, 32'd100, 32'd7, 5'd5, ns, td, r, d, nd);
        n_cmp++; if (r !== 32'd2)   begin n_err++; $display("FAIL remu_result: got %h exp %h", r, 32'd2); end
        run_op(DIVU, 32'hFFFF_FFFF, 32'd16, 5'd6, ns, td, r, d, nd);
        n_cmp++; if (r !== 32'h0FFF_FFFF) begin n_err++; $display("FAIL divu_big_result: got %h exp 0fffffff", r); end
        run_op(DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, ns, td, r, d, nd);
        n_cmp++; if (r !== 32'h0)   begin n_err++; $display("FAIL divu_min_by_ones: got %h exp 0", r); end
        run_op(REMU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, ns, td, r, d, nd);
        n_cmp++; if (r !== 32'h8000_0000) begin n_err++; $display("FAIL remu_min_by_ones: got %h exp 80000000", r); end
    endtask

    task automatic test_signed;
        int ns, td, nd; logic [31:0] r; logic [4:0] d;
        run_op(DIV, 32'hFFFF_FFF9, 32'd2, 5'd9, ns, td, r, d, nd);
        n_cmp++; if (r !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL div_m7_2: got %h exp fffffffd", r); end
        n_cmp++; if (d !== 5'd9)          begin n_err++; $display("FAIL div_rd_out: got %0d exp 9", d); end
        run_op(REM, 32'hFFFF_FFF9, 32'd2, 5'd9, ns, td, r, d, nd);
        n_cmp++; if (r !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL rem_m7_2: got %h exp ffffffff", r); end
        run_op(DIV, 32'd7, 32'hFFFF_FFFE, 5'd10, ns, td, r, d, nd);
        n_cmp++; if (r !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL div_7_m2: got %h exp fffffffd", r); end
        run_op(REM, 32'd7, 32'hFFFF_FFFE, 5'd10, ns, td, r, d, nd);
        n_cmp++; if (r !== 32'd1)         begin n_err++; $display("FAIL rem_7_m2: got %h exp 1", r); end
        run_op(DIV, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 5'd11, ns, td, r, d, nd);
        n_cmp++; if (r !== 32'd3)         begin n_err++; $display("FAIL div_m7_m2: got %h exp 3", r); end
        run_op(REM, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 5'd11, ns, td, r, d, nd);
        n_cmp++; if (r !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL rem_m7_m2: got %h exp ffffffff", r); end
    endtask

    task automatic test_special;
        int ns, td, nd; logic [31:0] r; logic [4:0] d;
        run_op(DIV, 32'd5, 32'd0, 5'd1, ns, td, r, d, nd);
        n_cmp++; if (r !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL div_by_zero: got %h exp ffffffff", r); end
        n_cmp++; if (td !== SP_LAT)       begin n_err++; $display("FAIL div_by_zero_latency: got %0d exp %0d", td, SP_LAT); end
        n_cmp++; if (ns !== SP_LAT)       begin n_err++; $display("FAIL div_by_zero_stall: got %0d exp %0d", ns, SP_LAT); end
        n_cmp++; if (nd !== 1)            begin n_err++; $display("FAIL div_by_zero_done_count: got %0d exp 1", nd); end
        run_op(REM, 32'd5, 32'd0, 5'd2, ns, td, r, d, nd);
        n_cmp++; if (r !== 32'd5)         begin n_err++; $display("FAIL rem_by_zero: got %h exp 5", r); end
        run_op(REMU, 32'hFFFF_FFF0, 32'd0, 5'd2, ns, td, r, d, nd);
        n_cmp++; if (r !== 32'hFFFF_FFF0) begin n_err++; $display("FAIL remu_by_zero: got %h exp fffffff0", r); end
        run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3, ns, td, r, d, nd);
        n_cmp++; if (r !== 32'h8000_0000) begin n_err++; $display("FAIL div_overflow: got %h exp 80000000", r); end
        n_cmp++; if (td !== SP_LAT)       begin n_err++; $display("FAIL div_overflow_latency: got %0d exp %0d", td, SP_LAT); end
        run_op(REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3, ns, td, r, d, nd);
        n_cmp++; if (r !== 32'h0)         begin n_err++; $display("FAIL rem_overflow: got %h exp 0", r); end
    endtask

    task automatic test_kill;
        int ns, td, nd; logic [31:0] r; logic [4:0] d;
        int n_done_after;
        run_op(DIVU, 32'd50, 32'd5, 5'd3, ns, td, r, d, nd);
        n_cmp++; if (r !== 32'd10) begin n_err++; $display("FAIL kill_pre_result: got %h exp a", r); end
        @(negedge clk);
        div_valid = 1'b1; div_funct3 = DIVU; div_a = 32'd100; div_b = 32'd7; div_rd = 5'd12;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            div_valid = 1'b0;
            if (k == 10) kill = 1'b1;
        end
        @(negedge clk);
        kill = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0)  begin n_err++; $display("FAIL kill_busy: got %b exp 0", busy); end
        n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL kill_stall: got %b exp 0", stall); end
        n_done_after = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk); #1;
            if (done) n_done_after++;
        end
        n_cmp++; if (n_done_after !== 0) begin n_err++; $display("FAIL kill_no_done: got %0d exp 0", n_done_after); end
        n_cmp++; if (result !== 32'd10)  begin n_err++; $display("FAIL kill_result_hold: got %h exp a", result); end
        n_cmp++; if (rd_out !== 5'd3)    begin n_err++; $display("FAIL kill_rd_hold: got %0d exp 3", rd_out); end
    endtask

    task automatic test_clr_mid;
        int ns, td, nd; logic [31:0] r; logic [4:0] d;
        int n_done_after;
        @(negedge clk);
        div_valid = 1'b1; div_funct3 = DIVU; div_a = 32'd100; div_b = 32'd7; div_rd = 5'd7;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            div_valid = 1'b0;
        end
        #1;
        clr = 1'b1;
        #1;
        n_cmp++; if (busy !== 1'b0)    begin n_err++; $display("FAIL clr_busy: got %b exp 0", busy); end
        n_cmp++; if (stall !== 1'b0)   begin n_err++; $display("FAIL clr_stall: got %b exp 0", stall); end
        n_cmp++; if (result !== 32'h0) begin n_err++; $display("FAIL clr_result: got %h exp 0", result); end
        n_cmp++; if (rd_out !== 5'h0)  begin n_err++; $display("FAIL clr_rd_out: got %0d exp 0", rd_out); end
        @(negedge clk);
        clr = 1'b0;
        n_done_after = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk); #1;
            if (done) n_done_after++;
        end
        n_cmp++; if (n_done_after !== 0) begin n_err++; $display("FAIL clr_no_done: got %0d exp 0", n_done_after); end
        run_op(DIVU, 32'd9, 32'd3, 5'd8, ns, td, r, d, nd);
        n_cmp++; if (r !== 32'd3) begin n_err++; $display("FAIL clr_next_op: got %h exp 3", r); end
    endtask

    task automatic test_back_to_back;
        int n_done_seen, t1, t2;
        logic [31:0] r1, r2;
        logic s33, s34;
        n_done_seen = 0; t1 = -1; t2 = -1; r1 = 'x; r2 = 'x; s33 = 1'bx; s34 = 1'bx;
        @(negedge clk);
        div_valid = 1'b1; div_funct3 = DIVU; div_a = 32'd100; div_b = 32'd7; div_rd = 5'd13;
        for (int k = 1; k <= 110; k++) begin
            @(negedge clk);
            div_valid = (k <= 67);
            #1;
            if (k == 33) s33 = stall;
            if (k == 34) s34 = stall;
            if (done) begin
                n_done_seen++;
                if (t1 < 0) begin t1 = k; r1 = result; end
                else if (t2 < 0) begin t2 = k; r2 = result; end
            end
        end
        n_cmp++; if (n_done_seen !== 2) begin n_err++; $display("FAIL b2b_done_count: got %0d exp 2", n_done_seen); end
        n_cmp++; if (t1 !== 33)         begin n_err++; $display("FAIL b2b_first_done: got %0d exp 33", t1); end
        n_cmp++; if (t2 !== 67)         begin n_err++; $display("FAIL b2b_second_done: got %0d exp 67", t2); end
        n_cmp++; if (s33 !== 1'b0)      begin n_err++; $display("FAIL b2b_stall_in_done: got %b exp 0", s33); end
        n_cmp++; if (s34 !== 1'b1)      begin n_err++; $display("FAIL b2b_stall_reaccept: got %b exp 1", s34); end
        n_cmp++; if (r1 !== 32'd14)     begin n_err++; $display("FAIL b2b_result1: got %h exp e", r1); end
        n_cmp++; if (r2 !== 32'd14)     begin n_err++; $display("FAIL b2b_result2: got %h exp e", r2); end
    endtask

    initial begin
        clr = 1'b1; div_valid = 1'b0; div_funct3 = DIVU; div_a = '0; div_b = '0;
        div_rd = '0; kill = 1'b0;
        test_reset();
        test_unsigned();
        test_signed();
        test_special();
        test_kill();
        test_clr_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_mdu_div_sequencer
`default_nettype wire
